// File: rtl/rgb888_to_565_packer_if.sv
// ---------------------------------------------------------------------------
// rgb888_to_565_packer_if
// Stream bundle for the RGB888 -> RGB565 packer.
//
// Handshake (applies to both directions): a beat transfers on a rising clock
// edge where its valid and ready are both high. A producer holding valid high
// keeps its payload stable until the beat transfers. The consumer's ready may
// depend combinationally on the consumer's own state and its downstream ready.
//
// Signals:
//   valid_in / ready_out          input beat handshake
//   sof_in                        first pixel of a frame (qualified by valid_in)
//   red_in, green_in, blue_in     8-bit colour components
//   valid_out / ready_in          output beat handshake
//   pixel_out                     packed {r5, g6, b5}
//   addr_out                      frame-buffer address of pixel_out
// Modports: slave = the packer, master = whoever drives pixels and sinks words.
// ---------------------------------------------------------------------------
interface rgb888_to_565_packer_if #(
   parameter int ADDR_W = 17
);
   logic              valid_in;
   logic              ready_out;
   logic              sof_in;
   logic [7:0]        red_in;
   logic [7:0]        green_in;
   logic [7:0]        blue_in;
   logic              valid_out;
   logic              ready_in;
   logic [15:0]       pixel_out;
   logic [ADDR_W-1:0] addr_out;

   modport slave (
      input  valid_in, sof_in, red_in, green_in, blue_in, ready_in,
      output ready_out, valid_out, pixel_out, addr_out
   );

   modport master (
      output valid_in, sof_in, red_in, green_in, blue_in, ready_in,
      input  ready_out, valid_out, pixel_out, addr_out
   );
endinterface

// File: rtl/rgb888_to_565_packer.sv
// ---------------------------------------------------------------------------
// rgb888_to_565_packer
// Streaming RGB888 -> RGB565 converter with round-to-nearest and saturation,
// plus linear frame-buffer address generation (addr = y*H_PIXELS + x).
// Two-stage valid/ready pipeline, one pixel per clock at full flow.
//   S1: rounded components and the pixel's address.
//   S2: packed word and address, driving the outputs.
//
// Ports:
//   clk_in   system clock, rising edge
//   rst_in   synchronous active-high reset
//   bus      rgb888_to_565_packer_if.slave (pixel in, packed word out)
//
// Optional feature: define RGB565_DITHER_EN to replace the fixed half-LSB
// rounding offset with a 2x2 ordered (Bayer) dither keyed on the pixel's x/y.
// ---------------------------------------------------------------------------
module rgb888_to_565_packer #(
   parameter int H_PIXELS = 320,
   parameter int V_PIXELS = 240,
   parameter int ADDR_W   = 17
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   rgb888_to_565_packer_if.slave       bus
);
   localparam int X_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int Y_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

   // Running position counters: where the next non-sof pixel lands.
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [ADDR_W-1:0] r_addr;

   logic              r_s1_valid;
   logic [4:0]        r_s1_r5;
   logic [5:0]        r_s1_g6;
   logic [4:0]        r_s1_b5;
   logic [ADDR_W-1:0] r_s1_addr;

   logic              r_s2_valid;
   logic [15:0]       r_s2_pix;
   logic [ADDR_W-1:0] r_s2_addr;

   logic              w_s2_load;
   logic              w_s1_advance;
   logic              w_s1_load;
   logic              w_accept;

   logic [X_W-1:0]    w_px_x;
   logic [Y_W-1:0]    w_px_y;
   logic [ADDR_W-1:0] w_px_addr;
   logic [X_W-1:0]    w_nx_x;
   logic [Y_W-1:0]    w_nx_y;
   logic [ADDR_W-1:0] w_nx_addr;

   logic [8:0]        w_off_rb;
   logic [8:0]        w_off_g;
   logic [8:0]        w_sum_r;
   logic [8:0]        w_sum_g;
   logic [8:0]        w_sum_b;
   logic [5:0]        w_sh_r;
   logic [6:0]        w_sh_g;
   logic [5:0]        w_sh_b;
   logic [4:0]        w_r5;
   logic [5:0]        w_g6;
   logic [4:0]        w_b5;

   // Handshake. S2 takes a new word when empty or when its word leaves this
   // cycle; ready_out therefore follows ready_in combinationally so a full
   // pipeline keeps streaming without a bubble.
   assign w_s2_load     = !r_s2_valid || bus.ready_in;
   assign w_s1_advance  = r_s1_valid && w_s2_load;
   assign w_s1_load     = !r_s1_valid || w_s1_advance;
   assign bus.ready_out = !rst_in && w_s1_load;
   assign w_accept      = bus.valid_in && bus.ready_out;

   // Position of the incoming pixel and the counters that follow it.
   always_comb begin
      w_px_x    = bus.sof_in ? '0 : r_x;
      w_px_y    = bus.sof_in ? '0 : r_y;
      w_px_addr = bus.sof_in ? '0 : r_addr;
      w_nx_x    = w_px_x + 1'b1;
      w_nx_y    = w_px_y;
      w_nx_addr = w_px_addr + 1'b1;
      if (w_px_x == X_LAST) begin
         w_nx_x = '0;
         if (w_px_y == Y_LAST) begin
            w_nx_y    = '0;
            w_nx_addr = '0;
         end else begin
            w_nx_y = w_px_y + 1'b1;
         end
      end
   end

`ifdef RGB565_DITHER_EN
   // Bayer 2x2 [[0,2],[3,1]] indexed [y0][x0]; red/blue use 2d+1, green d.
   logic [1:0] w_d;
   always_comb begin
      w_d = 2'd0;
      case ({w_px_y[0], w_px_x[0]})
         2'b00:   w_d = 2'd0;
         2'b01:   w_d = 2'd2;
         2'b10:   w_d = 2'd3;
         default: w_d = 2'd1;
      endcase
   end
   assign w_off_rb = {6'd0, w_d, 1'b1};
   assign w_off_g  = {7'd0, w_d};
`else
   assign w_off_rb = 9'd4;
   assign w_off_g  = 9'd2;
`endif

   // 9-bit sums: bit 8 set means the rounded value overflowed the field.
   assign w_sum_r = {1'b0, bus.red_in}   + w_off_rb;
   assign w_sum_g = {1'b0, bus.green_in} + w_off_g;
   assign w_sum_b = {1'b0, bus.blue_in}  + w_off_rb;
   assign w_sh_r  = 6'(w_sum_r >> 3);
   assign w_sh_g  = 7'(w_sum_g >> 2);
   assign w_sh_b  = 6'(w_sum_b >> 3);
   assign w_r5    = w_sh_r[5] ? 5'd31 : w_sh_r[4:0];
   assign w_g6    = w_sh_g[6] ? 6'd63 : w_sh_g[5:0];
   assign w_b5    = w_sh_b[5] ? 5'd31 : w_sh_b[4:0];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_x        <= '0;
         r_y        <= '0;
         r_addr     <= '0;
         r_s1_valid <= 1'b0;
         r_s1_r5    <= '0;
         r_s1_g6    <= '0;
         r_s1_b5    <= '0;
         r_s1_addr  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_pix   <= '0;
         r_s2_addr  <= '0;
      end else begin
         if (w_accept) begin
            r_x    <= w_nx_x;
            r_y    <= w_nx_y;
            r_addr <= w_nx_addr;
         end
         if (w_s1_load) begin
            r_s1_valid <= bus.valid_in;
            if (w_accept) begin
               r_s1_r5   <= w_r5;
               r_s1_g6   <= w_g6;
               r_s1_b5   <= w_b5;
               r_s1_addr <= w_px_addr;
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_pix  <= {r_s1_r5, r_s1_g6, r_s1_b5};
               r_s2_addr <= r_s1_addr;
            end
         end
      end
   end

   assign bus.valid_out = r_s2_valid;
   assign bus.pixel_out = r_s2_pix;
   assign bus.addr_out  = r_s2_addr;
endmodule

// File: tb/tb_rgb888_to_565_packer.sv
// ---------------------------------------------------------------------------
// tb_rgb888_to_565_packer
// Bench for rgb888_to_565_packer on a small 4x2 frame. A driver issues
// directed and random pixels and pushes each accepted pixel's expected
// {pixel, addr} into exp_q; an independent monitor pops and compares every
// word the DUT hands off and checks that stalled outputs hold.
// Builds with or without RGB565_DITHER_EN; the reference follows the macro.
// ---------------------------------------------------------------------------
module tb_rgb888_to_565_packer;
   localparam int H      = 4;
   localparam int V      = 2;
   localparam int ADDR_W = 17;
   localparam int EW     = 16 + ADDR_W;

   // ---------------- clock / reset ----------------
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk_in = ~clk_in;

   rgb888_to_565_packer_if #(.ADDR_W(ADDR_W)) bus ();

   rgb888_to_565_packer #(
      .H_PIXELS (H),
      .V_PIXELS (V),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus.slave)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int n_vec  = 0;
   int n_fail = 0;
   int pos    = 0;   // linear position of the next non-sof pixel

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: round-to-nearest (or ordered dither), saturate, pack.
   function automatic logic [15:0] model_pix(input int r, input int g, input int b,
                                             input int x, input int y);
      int orb, og, d, r5, g6, b5;
`ifdef RGB565_DITHER_EN
      if (y % 2 == 0) d = (x % 2 == 0) ? 0 : 2;
      else            d = (x % 2 == 0) ? 3 : 1;
      orb = 2 * d + 1;
      og  = d;
`else
      d   = 0;
      orb = 4 + d;
      og  = 2;
`endif
      r5 = (r + orb) / 8;  if (r5 > 31) r5 = 31;
      g6 = (g + og)  / 4;  if (g6 > 63) g6 = 63;
      b5 = (b + orb) / 8;  if (b5 > 31) b5 = 31;
      return 16'(r5 * 2048 + g6 * 32 + b5);
   endfunction

   // ---------------- driver ----------------
   // One clock cycle of stimulus; records the expected word if accepted.
   task automatic drive(input logic v, input logic s, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b,
                        input logic rdy, input logic rst);
      int x, y;
      @(negedge clk_in);
      rst_in       = rst;
      bus.valid_in = v;
      bus.sof_in   = s;
      bus.red_in   = r;
      bus.green_in = g;
      bus.blue_in  = b;
      bus.ready_in = rdy;
      #1;
      if (rst) begin
         exp_q.delete();
         pos = 0;
      end else if (v && bus.ready_out) begin
         if (s) pos = 0;
         x = pos % H;
         y = pos / H;
         exp_q.push_back({model_pix(int'(r), int'(g), int'(b), x, y), ADDR_W'(pos)});
         pos = (pos + 1) % (H * V);
      end
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, rdy, 1'b0);
   endtask

   function automatic logic [7:0] rnd_comp();
      logic [7:0] edge_vals[8] = '{8'h00, 8'hFF, 8'hFB, 8'hFC, 8'hFD, 8'h03, 8'h04, 8'h84};
      if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 7)];
      return 8'($urandom_range(0, 255));
   endfunction

   // ---------------- monitor ----------------
   logic              prev_stall = 1'b0;
   logic [15:0]       prev_pix;
   logic [ADDR_W-1:0] prev_addr;

   always @(negedge clk_in) begin
      logic [EW-1:0] e;
      #2;
      if (rst_in) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(bus.valid_out), 32'd1);
            chk("hold_pixel", 32'(bus.pixel_out), 32'(prev_pix));
            chk("hold_addr",  32'(bus.addr_out),  32'(prev_addr));
         end
         if (bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(bus.pixel_out), 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", 32'(bus.pixel_out), 32'(e[EW-1:ADDR_W]));
               chk("addr",  32'(bus.addr_out),  32'(e[ADDR_W-1:0]));
            end
         end
         prev_stall = bus.valid_out && !bus.ready_in;
         prev_pix   = bus.pixel_out;
         prev_addr  = bus.addr_out;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.valid_in = 1'b0;
      bus.sof_in   = 1'b0;
      bus.red_in   = '0;
      bus.green_in = '0;
      bus.blue_in  = '0;
      bus.ready_in = 1'b1;

      // Reset state.
      repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      chk("ready_in_reset", 32'(bus.ready_out), 32'd0);
      chk("valid_in_reset", 32'(bus.valid_out), 32'd0);
      idle(1'b1);
      chk("ready_after_reset", 32'(bus.ready_out), 32'd1);
      chk("pixel_after_reset", 32'(bus.pixel_out), 32'd0);
      chk("addr_after_reset",  32'(bus.addr_out),  32'd0);

      // First pixel with sof: two-cycle latency.
      drive(1'b1, 1'b1, 8'h84, 8'h82, 8'h04, 1'b1, 1'b0);
      idle(1'b1);
      chk("latency_c1_valid", 32'(bus.valid_out), 32'd0);
      idle(1'b1);
      chk("latency_c2_valid", 32'(bus.valid_out), 32'd1);
      chk("latency_c2_addr",  32'(bus.addr_out),  32'd0);
`ifndef RGB565_DITHER_EN
      chk("latency_c2_pixel", 32'(bus.pixel_out), 32'h8C21);
`endif

      // Saturation and zero.
      drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      idle(1'b1);
      chk("sat_pixel", 32'(bus.pixel_out), 32'hFFFF);
      idle(1'b1);
      chk("zero_pixel", 32'(bus.pixel_out), 32'h0000);

      // Ten pixels from sof: addresses 0..7,0,1 via the frame wrap.
      for (int i = 0; i < 10; i++)
         drive(1'b1, (i == 0), rnd_comp(), rnd_comp(), rnd_comp(), 1'b1, 1'b0);

      // Flat dither fields over full frames (plain rounding without the macro).
      for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 8'h10, 8'h10, 8'h10, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, (i == 0), 8'h13, 8'h13, 8'h13, 1'b1, 1'b0);

      // Stall under continuous flow: both stages full, ready_out low.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, rnd_comp(), rnd_comp(), rnd_comp(), 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, rnd_comp(), rnd_comp(), rnd_comp(), 1'b0, 1'b0);
         chk("stall_ready_low", 32'(bus.ready_out), 32'd0);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, rnd_comp(), rnd_comp(), rnd_comp(), 1'b1, 1'b0);

      // Reset with both stages full; next pixel without sof lands at 0.
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rnd_comp(), rnd_comp(), rnd_comp(), 1'b0, 1'b0);
      drive(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1);
      chk("ready_during_rst", 32'(bus.ready_out), 32'd0);
      idle(1'b1);
      chk("valid_after_rst", 32'(bus.valid_out), 32'd0);
      drive(1'b1, 1'b0, 8'h55, 8'hAA, 8'h5A, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      chk("post_rst_valid", 32'(bus.valid_out), 32'd1);
      chk("post_rst_addr",  32'(bus.addr_out),  32'd0);

      // Random traffic with random back-pressure and occasional sof.
      for (int i = 0; i < 400; i++)
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
               rnd_comp(), rnd_comp(), rnd_comp(),
               ($urandom_range(0, 3) != 0), 1'b0);

      // Drain with a bounded wait.
      for (int i = 0; i < 30; i++) begin
         if (exp_q.size() == 0) break;
         idle(1'b1);
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
